// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the ID->WB control-signal pipeline.
// ctrl_bundle_t packs the main decoder outputs; CTRL_NOP is the bubble value.
package ctrl_pipe_pkg;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [2:0] mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       pc_sel;
  } ctrl_bundle_t;

  localparam int CTRL_BUNDLE_W = $bits(ctrl_bundle_t);

  // Bubble content: no memory write, no register write, sequential PC.
  localparam ctrl_bundle_t CTRL_NOP = '0;

  localparam int ST_IDEX  = 0;
  localparam int ST_EXMEM = 1;
  localparam int ST_MEMWB = 2;

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// Decoder-side handshake and stage outputs of ctrl_pipe_chain.
// master = decoder / hazard unit side, slave = the pipeline itself.
interface ctrl_pipe_chain_if #(
  parameter int CTRL_W   = 10,
  parameter int N_STAGES = 3
);
  logic [CTRL_W-1:0]          ctrl_in;
  logic                       valid_in;
  logic                       hold_all;
  logic                       stall;
  logic                       flush;
  logic                       id_ready;
  logic [N_STAGES*CTRL_W-1:0] ctrl_stage_o;
  logic [N_STAGES-1:0]        valid_stage_o;

  modport master (
    output ctrl_in, valid_in, hold_all, stall, flush,
    input  id_ready, ctrl_stage_o, valid_stage_o
  );

  modport slave (
    input  ctrl_in, valid_in, hold_all, stall, flush,
    output id_ready, ctrl_stage_o, valid_stage_o
  );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// One control pipeline register: CTRL_W bits of control plus a valid bit.
// Invalid or bubbled input is stored as CTRL_NOP so an empty stage never drives stray enables.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic [CTRL_W-1:0] d,
  input  logic              d_valid,
  output logic [CTRL_W-1:0] q,
  output logic              q_valid
);

  // NOTE: async clear in the sensitivity list, and <= for every register so all
  // stages sample the previous-cycle values of their neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= CTRL_W'(CTRL_NOP);
      q_valid <= 1'b0;
    end else if (!hold) begin
      if (bubble || !d_valid) begin
        q       <= CTRL_W'(CTRL_NOP);
        q_valid <= 1'b0;
      end else begin
        q       <= d;
        q_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Parametrised ID->WB control pipeline with global hold, load-use bubble and branch flush.
// Optional perf counters (stall/flush/retire) are built when PERF_CNT_EN is defined.
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W      = CTRL_BUNDLE_W,
  parameter int N_STAGES    = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  ctrl_pipe_chain_if.slave   bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o,
  output logic [CNT_W-1:0]   retire_cnt_o
`endif
);

  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > N_STAGES || CNT_W < 1) begin : g_bad_params
    $error("ctrl_pipe_chain: FLUSH_DEPTH must be 1..N_STAGES and CNT_W >= 1");
  end

  logic [CTRL_W-1:0]   stage_ctrl [N_STAGES];
  logic [N_STAGES-1:0] stage_valid;

  // A flush discards the ID bundle, so it also counts as consuming it.
  assign bus.id_ready = ~bus.hold_all & (~bus.stall | bus.flush);

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic [CTRL_W-1:0] d;
    logic              d_valid;
    logic              bubble;

    if (k == 0) begin : g_head
      assign d       = bus.ctrl_in;
      assign d_valid = bus.valid_in;
      assign bubble  = bus.flush | bus.stall;
    end else begin : g_body
      assign d       = stage_ctrl[k-1];
      assign d_valid = stage_valid[k-1];
      if (k < FLUSH_DEPTH) begin : g_killable
        assign bubble = bus.flush;
      end else begin : g_kept
        assign bubble = 1'b0;
      end
    end

    ctrl_pipe_stage #(.CTRL_W(CTRL_W)) u_stage (
      .clk     (clk),
      .rst_n   (reset_n),
      .hold    (bus.hold_all),
      .bubble  (bubble),
      .d       (d),
      .d_valid (d_valid),
      .q       (stage_ctrl[k]),
      .q_valid (stage_valid[k])
    );

    assign bus.ctrl_stage_o[k*CTRL_W +: CTRL_W] = stage_ctrl[k];
  end

  assign bus.valid_stage_o = stage_valid;

`ifdef PERF_CNT_EN
  logic stall_acc;
  logic flush_acc;
  logic retire;

  assign stall_acc = ~bus.hold_all & ~bus.flush & bus.stall;
  assign flush_acc = ~bus.hold_all & bus.flush;
  assign retire    = ~bus.hold_all & stage_valid[N_STAGES-1];

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
      retire_cnt_o <= '0;
    end else begin
      if (stall_acc && !(&stall_cnt_o))   stall_cnt_o  <= stall_cnt_o + 1'b1;
      if (flush_acc && !(&flush_cnt_o))   flush_cnt_o  <= flush_cnt_o + 1'b1;
      if (retire && !(&retire_cnt_o))     retire_cnt_o <= retire_cnt_o + 1'b1;
    end
  end
`endif

endmodule
